// File: rtl/lsu_pkg.sv
// Shared types and widths for the load/store unit.
// Request latch struct, FSM state enum, default bus widths.
package lsu_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } lsu_state_t;

  typedef struct packed {
    logic              store;
    logic              inc;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } lsu_req_t;

endpackage

// File: rtl/lsu_if.sv
// Request, response and memory-side signals of the load/store unit.
// slave = the unit itself, master = CPU/memory side.
interface lsu_if;
  import lsu_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_store;
  logic              req_inc;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic [ADDR_W-1:0] rsp_next_addr;
  logic              rsp_err;

  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  req_valid, req_store, req_inc,
    input  req_addr, req_wdata,
    input  rsp_ready, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata,
    output rsp_next_addr, rsp_err,
    output mem_read, mem_write,
    output mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_store, req_inc,
    output req_addr, req_wdata,
    output rsp_ready, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata,
    input  rsp_next_addr, rsp_err,
    input  mem_read, mem_write,
    input  mem_addr, mem_wdata
  );

endinterface

// File: rtl/lsu_perf_counters.sv
// Saturating per-type response counters (loads, stores, faults).
// Only built when LSU_PERF_EN is defined.
`ifdef LSU_PERF_EN
module lsu_perf_counters (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        done,
  input  logic        is_store,
  input  logic        is_fault,
  output logic [15:0] loads,
  output logic [15:0] stores,
  output logic [15:0] faults
);

  logic [15:0] loads_q, loads_d;
  logic [15:0] stores_q, stores_d;
  logic [15:0] faults_q, faults_d;

  function automatic logic [15:0] sat_inc(
    input logic [15:0] v
  );
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_comb begin
    loads_d  = loads_q;
    stores_d = stores_q;
    faults_d = faults_q;
    if (done) begin
      unique case (1'b1)
        is_fault: faults_d = sat_inc(faults_q);
        is_store: stores_d = sat_inc(stores_q);
        default:  loads_d  = sat_inc(loads_q);
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      loads_q  <= '0;
      stores_q <= '0;
      faults_q <= '0;
    end else begin
      loads_q  <= loads_d;
      stores_q <= stores_d;
      faults_q <= faults_d;
    end
  end

  assign loads  = loads_q;
  assign stores = stores_q;
  assign faults = faults_q;

endmodule
`endif

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit with post-increment and address fault.
// LSU_PERF_EN adds perf_loads/perf_stores/perf_faults counters.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter logic [ADDR_W-1:0] ADDR_LIMIT = '1
) (
  input  logic        clk,
  input  logic        rst_n,
  lsu_if.slave        bus
`ifdef LSU_PERF_EN
  ,
  output logic [15:0] perf_loads,
  output logic [15:0] perf_stores,
  output logic [15:0] perf_faults
`endif
);

  lsu_state_t        state_q, state_d;
  lsu_req_t          req_q, req_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic req_ready;
  logic rsp_valid;
  logic mem_read;
  logic mem_write;

  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    err_d     = err_q;
    rdata_d   = rdata_q;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    unique case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (bus.req_valid) begin
          req_d = '{
            store: bus.req_store,
            inc:   bus.req_inc,
            addr:  bus.req_addr,
            wdata: bus.req_wdata
          };
          err_d   = bus.req_addr > ADDR_LIMIT;
          rdata_d = '0;
          state_d = err_d ? RESP : ACCESS;
        end
      end
      ACCESS: begin
        mem_read  = !req_q.store;
        mem_write = req_q.store;
        if (!req_q.store) begin
          rdata_d = bus.mem_rdata;
        end
        state_d = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (bus.rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Reset drops any in-flight access, so no write pulse can follow it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      req_q   <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  assign bus.req_ready     = req_ready;
  assign bus.rsp_valid     = rsp_valid;
  assign bus.rsp_rdata     = rdata_q;
  assign bus.rsp_err       = err_q;
  assign bus.rsp_next_addr = req_q.inc
                           ? req_q.addr + ADDR_W'(1)
                           : req_q.addr;
  assign bus.mem_read      = mem_read;
  assign bus.mem_write     = mem_write;
  assign bus.mem_addr      = req_q.addr;
  assign bus.mem_wdata     = req_q.wdata;

`ifdef LSU_PERF_EN
  lsu_perf_counters u_perf (
    .clk      (clk),
    .rst_n    (rst_n),
    .done     (rsp_valid && bus.rsp_ready),
    .is_store (req_q.store),
    .is_fault (err_q),
    .loads    (perf_loads),
    .stores   (perf_stores),
    .faults   (perf_faults)
  );
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench: two LSUs (default limit and limit 8'hEF) on one memory.
// Memory default contents are addr ^ 8'h5A until written.
module tb_load_store_unit;

  typedef struct {
    logic [7:0] rdata;
    logic [7:0] nxt;
    logic       err;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  exp_t qa[$];
  exp_t qf[$];

  logic       v_a = 1'b0;
  logic       v_f = 1'b0;
  logic       r_st = 1'b0;
  logic       r_inc = 1'b0;
  logic [7:0] r_ad = '0;
  logic [7:0] r_wd = '0;
  logic       rdy = 1'b1;
  logic       sel_r = 1'b0;

  bit         wr_v[256];
  logic [7:0] wr_d[256];
  int         wc_a = 0;
  int         wc_f = 0;

  lsu_if a();
  lsu_if f();

  assign a.req_valid = v_a;
  assign a.req_store = r_st;
  assign a.req_inc   = r_inc;
  assign a.req_addr  = r_ad;
  assign a.req_wdata = r_wd;
  assign a.rsp_ready = rdy;
  assign f.req_valid = v_f;
  assign f.req_store = r_st;
  assign f.req_inc   = r_inc;
  assign f.req_addr  = r_ad;
  assign f.req_wdata = r_wd;
  assign f.rsp_ready = rdy;

  assign a.mem_rdata = wr_v[a.mem_addr] ? wr_d[a.mem_addr]
                     : (a.mem_addr ^ 8'h5A);
  assign f.mem_rdata = wr_v[f.mem_addr] ? wr_d[f.mem_addr]
                     : (f.mem_addr ^ 8'h5A);

  always @(posedge clk) begin
    if (a.mem_write) begin
      wr_v[a.mem_addr] <= 1'b1;
      wr_d[a.mem_addr] <= a.mem_wdata;
      wc_a <= wc_a + 1;
    end
    if (f.mem_write) begin
      wr_v[f.mem_addr] <= 1'b1;
      wr_d[f.mem_addr] <= f.mem_wdata;
      wc_f <= wc_f + 1;
    end
  end

`ifdef LSU_PERF_EN
  logic [15:0] pa_l, pa_s, pa_f;
  logic [15:0] pf_l, pf_s, pf_f;
`endif

  load_store_unit dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (a)
`ifdef LSU_PERF_EN
    ,
    .perf_loads  (pa_l),
    .perf_stores (pa_s),
    .perf_faults (pa_f)
`endif
  );

  load_store_unit #(.ADDR_LIMIT(8'hEF)) dut_f (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (f)
`ifdef LSU_PERF_EN
    ,
    .perf_loads  (pf_l),
    .perf_stores (pf_s),
    .perf_faults (pf_f)
`endif
  );

  logic       m_ready, m_valid, m_read, m_write;
  logic [7:0] m_addr, m_wdata;
  assign m_ready = sel_r ? f.req_ready : a.req_ready;
  assign m_valid = sel_r ? f.rsp_valid : a.rsp_valid;
  assign m_read  = sel_r ? f.mem_read  : a.mem_read;
  assign m_write = sel_r ? f.mem_write : a.mem_write;
  assign m_addr  = sel_r ? f.mem_addr  : a.mem_addr;
  assign m_wdata = sel_r ? f.mem_wdata : a.mem_wdata;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (a.rsp_valid && a.rsp_ready) begin
      if (qa.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL a_unexpected got rsp want none");
      end else begin
        exp_t e;
        e = qa.pop_front();
        chk("a_rdata", 32'(a.rsp_rdata), 32'(e.rdata));
        chk("a_next", 32'(a.rsp_next_addr), 32'(e.nxt));
        chk("a_err", 32'(a.rsp_err), 32'(e.err));
      end
    end
  end

  always @(negedge clk) begin
    if (f.rsp_valid && f.rsp_ready) begin
      if (qf.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL f_unexpected got rsp want none");
      end else begin
        exp_t e;
        e = qf.pop_front();
        chk("f_rdata", 32'(f.rsp_rdata), 32'(e.rdata));
        chk("f_next", 32'(f.rsp_next_addr), 32'(e.nxt));
        chk("f_err", 32'(f.rsp_err), 32'(e.err));
      end
    end
  end

  task automatic issue(input bit sel, input bit st,
                       input bit inc, input logic [7:0] ad,
                       input logic [7:0] wd,
                       input logic [7:0] er, input bit err);
    exp_t e;
    int n;
    e.rdata = er;
    e.nxt   = inc ? 8'(ad + 8'd1) : ad;
    e.err   = err;
    if (sel) qf.push_back(e);
    else qa.push_back(e);
    @(negedge clk);
    sel_r = sel;
    r_st  = st;
    r_inc = inc;
    r_ad  = ad;
    r_wd  = wd;
    v_a   = !sel;
    v_f   = sel;
    n = 0;
    while (!m_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("accept_timeout", 32'(n), 32'd0);
    @(posedge clk);
    #1;
    v_a = 1'b0;
    v_f = 1'b0;
    @(negedge clk);
    if (err) begin
      chk("flt_valid", 32'(m_valid), 32'd1);
      chk("flt_wr", 32'(m_write), 32'd0);
      chk("flt_rd", 32'(m_read), 32'd0);
    end else begin
      chk("acc_valid", 32'(m_valid), 32'd0);
      chk("acc_wr", 32'(m_write), 32'(st));
      chk("acc_rd", 32'(m_read), 32'(!st));
      chk("acc_addr", 32'(m_addr), 32'(ad));
      if (st) chk("acc_wdata", 32'(m_wdata), 32'(wd));
      @(negedge clk);
      chk("rsp_lat", 32'(m_valid), 32'd1);
      chk("rsp_wr", 32'(m_write), 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int wc0;
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(a.req_ready), 32'd1);
    chk("rst_valid", 32'(a.rsp_valid), 32'd0);
    chk("rst_rd", 32'(a.mem_read), 32'd0);
    chk("rst_wr", 32'(a.mem_write), 32'd0);
    chk("rst_addr", 32'(a.mem_addr), 32'd0);
    chk("rst_wdata", 32'(a.mem_wdata), 32'd0);
    chk("rst_rdata", 32'(a.rsp_rdata), 32'd0);
    chk("rst_next", 32'(a.rsp_next_addr), 32'd0);
    chk("rst_err", 32'(a.rsp_err), 32'd0);
    rst_n = 1'b1;

    // store then load
    issue(0, 1, 0, 8'h10, 8'hA5, 8'h00, 0);
    chk("st_pulses", 32'(wc_a), 32'd1);
    issue(0, 0, 0, 8'h10, 8'h00, 8'hA5, 0);
    // post-increment wrap and no-inc
    issue(0, 0, 1, 8'hFF, 8'h00, 8'hA5, 0);
    issue(0, 0, 0, 8'h20, 8'h00, 8'h7A, 0);

    // fault on limited unit, then boundary-legal load
    issue(1, 1, 0, 8'hF0, 8'h33, 8'h00, 1);
    issue(1, 0, 1, 8'hEF, 8'h00, 8'hB5, 0);
    chk("flt_no_write", 32'(wc_f), 32'd0);
    issue(0, 0, 0, 8'hF0, 8'h00, 8'hAA, 0);

    // backpressure
    @(posedge clk);
    #1 rdy = 1'b0;
    issue(0, 0, 0, 8'h10, 8'h00, 8'hA5, 0);
    wc0 = wc_a;
    r_st = 1'b1;
    r_inc = 1'b0;
    r_ad = 8'h30;
    r_wd = 8'h99;
    v_a = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid", 32'(a.rsp_valid), 32'd1);
      chk("bp_rdata", 32'(a.rsp_rdata), 32'hA5);
      chk("bp_ready", 32'(a.req_ready), 32'd0);
    end
    @(posedge clk);
    #1;
    rdy = 1'b1;
    v_a = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("bp_idle", 32'(a.req_ready), 32'd1);
    chk("bp_ignored", 32'(wc_a - wc0), 32'd0);
    issue(0, 0, 0, 8'h30, 8'h00, 8'h6A, 0);

    // reset during a store access
    wc0 = wc_a;
    @(negedge clk);
    sel_r = 1'b0;
    r_st = 1'b1;
    r_inc = 1'b0;
    r_ad = 8'h05;
    r_wd = 8'h3C;
    v_a = 1'b1;
    @(posedge clk);
    #1;
    v_a = 1'b0;
    chk("mid_access", 32'(a.mem_write), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_wr", 32'(a.mem_write), 32'd0);
    chk("mid_addr", 32'(a.mem_addr), 32'd0);
    chk("mid_wdata", 32'(a.mem_wdata), 32'd0);
    chk("mid_valid", 32'(a.rsp_valid), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_idle", 32'(a.req_ready), 32'd1);
    chk("mid_nowrite", 32'(wc_a - wc0), 32'd0);
    issue(0, 0, 0, 8'h05, 8'h00, 8'h5F, 0);

`ifdef LSU_PERF_EN
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    issue(0, 0, 0, 8'h01, 8'h00, 8'h5B, 0);
    issue(0, 1, 0, 8'h40, 8'h11, 8'h00, 0);
    issue(0, 0, 1, 8'h02, 8'h00, 8'h58, 0);
    issue(0, 1, 0, 8'h41, 8'h22, 8'h00, 0);
    issue(0, 0, 0, 8'h03, 8'h00, 8'h59, 0);
    issue(1, 0, 0, 8'hF5, 8'h00, 8'h00, 1);
    repeat (2) @(negedge clk);
    chk("perf_loads", 32'(pa_l), 32'd3);
    chk("perf_stores", 32'(pa_s), 32'd2);
    chk("perf_faults_a", 32'(pa_f), 32'd0);
    chk("perf_faults_f", 32'(pf_f), 32'd1);
    chk("perf_loads_f", 32'(pf_l), 32'd0);
`endif

    repeat (3) @(negedge clk);
    chk("qa_drained", 32'(qa.size()), 32'd0);
    chk("qf_drained", 32'(qf.size()), 32'd0);
    chk("f_total_writes", 32'(wc_f), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits between the CPU execute stage and the 256x8 data memory.
- Accepts one load/store request at a time over a valid/ready handshake and drives the memory's read-enable, write-enable, address and write-data inputs for exactly one cycle.
- Captures the combinational read data and presents a registered response to writeback.
- Supports optional post-increment addressing (pointer++ idiom) and an address-limit fault.

Parameters:
- DATA_W, 8, data width; must match the memory word.
- ADDR_W, 8, address width; 256-entry space.
- ADDR_LIMIT, 8'hFF, highest legal address. Any request above it faults. Default means no faults.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  1  request present
- req_ready  output  1  unit can accept a request
- req_store  input  1  1 = store, 0 = load
- req_inc  input  1  post-increment: response returns addr+1
- req_addr  input  ADDR_W  byte address
- req_wdata  input  DATA_W  store data
- rsp_valid  output  1  response present
- rsp_ready  input  1  writeback accepts response
- rsp_rdata  output  DATA_W  load data; 0 for stores and faults
- rsp_next_addr  output  ADDR_W  updated pointer
- rsp_err  output  1  address fault
- mem_read  output  1  to memory read enable
- mem_write  output  1  to memory write enable
- mem_addr  output  ADDR_W  to memory address
- mem_wdata  output  DATA_W  to memory write data
- mem_rdata  input  DATA_W  from memory; combinational, valid same cycle as mem_read

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - All internal registers and outputs are 0, except req_ready, which is 1 once in IDLE.
  - A pending access is abandoned; no mem_write pulse occurs after reset is asserted.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid: latch store, inc, addr, wdata.
  - If addr > ADDR_LIMIT, set err_q=1 and go to RESP without touching memory.
  - Otherwise go to ACCESS.
- ACCESS (exactly 1 cycle), req_ready=0:
  - mem_addr=addr_q.
  - Load: mem_read=1; rdata_q <= mem_rdata at the end of the cycle.
  - Store: mem_write=1, mem_wdata=wdata_q; the memory commits at the edge ending ACCESS.
  - Next state RESP.
- RESP:
  - rsp_valid=1, held with all rsp_* fields stable until rsp_ready=1, then go to IDLE.
  - req_ready=0 throughout; no overlap.
- mem_read and mem_write are 0 in every state except ACCESS, and never both 1.
- mem_addr and mem_wdata show the latched registers at all times; 0 after reset.
- Latency:
  - Request accepted at edge N; memory access during cycle N+1; rsp_valid from cycle N+2.
  - Minimum 3 cycles per request with rsp_ready tied high.
- rsp_next_addr:
  - addr_q+1 mod 2^ADDR_W when inc=1 (8'hFF wraps to 8'h00), else addr_q.
  - Computed even on fault.
- Faulted requests: rsp_err=1 and rsp_rdata=0; the memory sees no pulse.
- rsp_rdata is 0 for stores.
- Requests presented while req_ready=0 are ignored; the upstream stage must hold them.

Optional Feature:
- Macro: LSU_PERF_EN.
- With the macro defined:
  - Adds output ports perf_loads, perf_stores and perf_faults, 16 bits each.
  - Each counter increments once per completed response (the RESP handshake) of its type, saturating at 16'hFFFF.
  - All counters clear on reset.
- Without the macro: the ports and logic are absent; all other behaviour is identical.

Decomposition:
- Package lsu_pkg holds:
  - lsu_state_t enum (IDLE, ACCESS, RESP)
  - DATA_W/ADDR_W default constants
  - a request struct (store, inc, addr, wdata) used for the latch register
- Optional sub-module lsu_perf_counters: three saturating counters, instantiated only under LSU_PERF_EN.
- The core FSM stays in load_store_unit.

Test Plan:
- Store then load: store addr 8'h10 data 8'hA5 -> one-cycle mem_write pulse with mem_addr=8'h10. Then load 8'h10 -> rsp_rdata=8'hA5, rsp_err=0, rsp_valid 2 cycles after acceptance.
- Post-increment wrap: load addr 8'hFF with inc=1 -> rsp_next_addr=8'h00. Load 8'h20 with inc=0 -> rsp_next_addr=8'h20.
- Fault (ADDR_LIMIT=8'hEF): store to 8'hF0 -> rsp_err=1, rsp_rdata=0, mem_write never asserted. A later load of 8'hF0 with a legal limit still returns the old data.
- Backpressure: hold rsp_ready=0 for 5 cycles on a load of 8'hA5 data -> rsp_valid and rsp_rdata stay stable, req_ready=0, and a new req_valid is ignored. Release -> IDLE next cycle, then the next request is accepted.
- Reset mid-op: assert rst_n=0 during ACCESS of a store of 8'h3C to 8'h05 -> outputs are 0 immediately and the state is IDLE after release. A load of 8'h05 then returns its pre-store value.
- LSU_PERF_EN: 3 loads, 2 stores, 1 fault -> perf_loads=3, perf_stores=2, perf_faults=1. Forced near saturation, the counters stick at 16'hFFFF.
